ntt_butterfly_stage: RTL and testbench
======================================

# ntt_butterfly_stage

Streaming radix-2 Cooley–Tukey butterfly that sits directly downstream of `simple_ntt`. It consumes coefficient pairs (a, b) from its `out_stream`, together with a per-pair twiddle w. It computes t = w·b mod q with a bit-serial modular multiplier and emits (a+t) mod q followed by (a−t) mod q on its own output stream. It is the first arithmetic layer of the NTT pipeline.

## Interface
- `data_width`, 32, coefficient/twiddle width; multiplier runs `data_width` iterations
- `modulus`, 3329, prime q; legal range 2 ≤ q ≤ 2^data_width − 1
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `in_stream`  in  data_width  coefficient word (a first, then b)
- `in_valid`  in  1  `in_stream` valid this cycle
- `twiddle`  in  data_width  w, sampled together with b
- `in_ready`  out  1  block accepts a word this cycle (combinational from state)
- `out_stream`  out  data_width  registered result word
- `out_valid`  out  1  registered; `out_stream` holds a result this cycle
- `busy`  out  1  high in every state except S_IDLE
- `range_err`  out  1  sticky out-of-range flag (see Configuration)

## Operation
- Transfer: a word is accepted on a rising edge where `in_valid && in_ready`.
- States and transitions:
  - S_IDLE: `in_ready`=1. On transfer, capture a and go to S_WAIT_B.
  - S_WAIT_B: `in_ready`=1. On transfer, capture b and w, clear r and the counter, and go to S_MUL.
  - S_MUL: `in_ready`=0. Runs for exactly `data_width` cycles, then goes to S_OUT_SUM.
  - S_OUT_SUM: go to S_OUT_DIF.
  - S_OUT_DIF: go to S_IDLE.
- Multiplier: processes w MSB-first. On each iteration:
  - r ← 2r; if r ≥ q then r ← r − q.
  - If the current w bit is 1: r ← r + b; if r ≥ q then r ← r − q.
  - The intermediate datapath is `data_width`+1 bits wide. No overflow occurs when a, b, w < q.
  - After the final iteration, t = r.
- Sum: s = a + t on `data_width`+1 bits; subtract q if s ≥ q.
- Difference: if a ≥ t, d = a − t; otherwise d = a − t + q.
- No downstream backpressure. Each result word is a one-cycle `out_valid` pulse.
- `in_valid` is ignored in S_MUL, S_OUT_SUM and S_OUT_DIF. Those words are dropped, not queued.
- Reset in any state, including mid-S_MUL:
  - next state is S_IDLE
  - `out_stream`=0, `out_valid`=0, `range_err`=0
  - r, counter, a, b and w are cleared
  - `in_ready`=0 while `reset` is high

## Timing
- Reset values: `out_stream`=0, `out_valid`=0, `busy`=0, `range_err`=0. `in_ready`=1 from the first cycle after `reset` deasserts.
- Edge numbering: b is accepted at edge E.
  - Iterations complete at edges E+1 … E+`data_width`.
  - After edge E+`data_width`+1: `out_stream`=sum, `out_valid`=1.
  - After edge E+`data_width`+2: `out_stream`=difference, `out_valid`=1.
  - After edge E+`data_width`+3: `out_valid`=0 and `in_ready`=1. `out_stream` holds the difference until the next result.
- Minimum pair period: `data_width`+4 cycles (36 at default).
- `busy` rises the cycle after a is accepted and falls on return to S_IDLE.

## Configuration
- `NTT_BFLY_RANGE_CHECK_EN` defined:
  - Each accepted a, b and w is compared against q.
  - Any value ≥ q is captured as 0 and sets `range_err`.
  - `range_err` stays set until `reset`.
- Not defined:
  - No comparators are present and `range_err` is tied to 0.
  - Inputs ≥ q produce results that are not guaranteed correct.

## Test plan
- Basic pair: q=3329, a=5, b=7, w=3 -> t=21; `out_stream`=26, then 3313. Each word valid for exactly 1 cycle, at E+33 and E+34.
- Wrap both ways: a=3000, b=1000, w=2 -> t=2000; sum 1671 (reduced), difference 1000.
- Multiplier reduction: a=0, b=3328, w=3328 -> t=1; outputs 1, then 3328.
- Busy drop: hold `in_valid`=1 with words 10,11,12… through a whole pair -> only the first two words are consumed. `in_ready`=0 for 34 cycles. The next accepted a is the word present when S_IDLE returns.
- Mid-operation reset: assert `reset` for 1 cycle at E+10 -> no `out_valid` pulse. All outputs are 0 and S_IDLE is entered. A following pair a=1, b=1, w=1 yields 2, then 0.
- With `NTT_BFLY_RANGE_CHECK_EN`: a=3329, b=4, w=1 -> `range_err`=1. Outputs 4, then 3325. The flag persists across later legal pairs until `reset`.

Source files
------------

// File: rtl/ntt_butterfly_stage.sv
// ntt_butterfly_stage: streaming radix-2 CT butterfly (a+w*b, a-w*b mod q) using a bit-serial modular multiplier.
// Define NTT_BFLY_RANGE_CHECK_EN to zero out-of-range inputs and raise the sticky range_err flag.
module ntt_butterfly_stage #(
  parameter int data_width = 32,
  parameter int modulus = 3329
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] in_stream,
  input  logic                  in_valid,
  input  logic [data_width-1:0] twiddle,
  output logic                  in_ready,
  output logic [data_width-1:0] out_stream,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  range_err
);
  localparam logic [data_width:0] Q = (data_width+1)'(modulus);
  localparam int CW = $clog2(data_width + 1);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_B, S_MUL, S_OUT_SUM, S_OUT_DIF} state_t;
  state_t state_q, state_d;
  logic [data_width-1:0] a_q, a_d, b_q, b_d, w_q, w_d, out_q, out_d, a_in, w_in;
  logic [data_width:0] r_q, r_d, r_dbl, r_red, r_add, r_nxt, sum, sum_r, dif;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ov_q, ov_d, xfer;
  assign in_ready = !reset && (state_q == S_IDLE || state_q == S_WAIT_B);
  assign xfer = in_valid && in_ready;
  assign busy = state_q != S_IDLE;
  assign out_stream = out_q;
  assign out_valid = ov_q;
`ifdef NTT_BFLY_RANGE_CHECK_EN
  logic a_bad, w_bad, range_err_q, range_err_d;
  assign a_bad = {1'b0, in_stream} >= Q;
  assign w_bad = {1'b0, twiddle} >= Q;
  assign a_in = a_bad ? '0 : in_stream;
  assign w_in = w_bad ? '0 : twiddle;
  assign range_err_d = range_err_q | (xfer & ((state_q == S_IDLE & a_bad) | (state_q == S_WAIT_B & (a_bad | w_bad))));
  always_ff @(posedge clk) range_err_q <= reset ? 1'b0 : range_err_d;
  assign range_err = range_err_q;
`else
  assign a_in = in_stream;
  assign w_in = twiddle;
  assign range_err = 1'b0;
`endif
  // One MSB-first double-and-add step; r stays below q so W+1 bits never overflow.
  assign r_dbl = r_q << 1;
  assign r_red = r_dbl >= Q ? r_dbl - Q : r_dbl;
  assign r_add = r_red + {1'b0, b_q};
  assign r_nxt = w_q[data_width-1] ? (r_add >= Q ? r_add - Q : r_add) : r_red;
  assign sum = {1'b0, a_q} + r_q;
  assign sum_r = sum >= Q ? sum - Q : sum;
  assign dif = {1'b0, a_q} >= r_q ? {1'b0, a_q} - r_q : {1'b0, a_q} + Q - r_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    w_d = w_q;
    r_d = r_q;
    cnt_d = cnt_q;
    out_d = out_q;
    ov_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        a_d = xfer ? a_in : a_q;
        state_d = xfer ? S_WAIT_B : S_IDLE;
      end
      S_WAIT_B: if (xfer) begin
        b_d = a_in;
        w_d = w_in;
        r_d = '0;
        cnt_d = '0;
        state_d = S_MUL;
      end
      S_MUL: begin
        r_d = r_nxt;
        w_d = w_q << 1;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(data_width - 1) ? S_OUT_SUM : S_MUL;
      end
      S_OUT_SUM: begin
        out_d = data_width'(sum_r);
        ov_d = 1'b1;
        state_d = S_OUT_DIF;
      end
      S_OUT_DIF: begin
        out_d = data_width'(dif);
        ov_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      w_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      w_q <= w_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ov_q <= ov_d;
    end
  end
endmodule

// File: tb/tb_ntt_butterfly_stage.sv
// tb_ntt_butterfly_stage: directed table, hand sequences and randomized pairs checked against a modular-arithmetic model.
module tb_ntt_butterfly_stage;
  localparam longint Q = 3329;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] in_stream = '0;
  logic in_valid = 1'b0;
  logic [31:0] twiddle = '0;
  logic in_ready, out_valid, busy, range_err;
  logic [31:0] out_stream;
  int checks = 0;
  int failures = 0;
  ntt_butterfly_stage #(.data_width(32), .modulus(3329)) dut (
    .clk(clk), .reset(reset), .in_stream(in_stream), .in_valid(in_valid), .twiddle(twiddle),
    .in_ready(in_ready), .out_stream(out_stream), .out_valid(out_valid), .busy(busy), .range_err(range_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a, b, w, s, d;
  } vec_t;
  vec_t vecs[4];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_stream", out_stream, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_range_err", range_err, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
  endtask
  task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                          output logic [31:0] s, output logic [31:0] d);
    int lat;
    in_valid = 1'b1;
    in_stream = a;
    @(negedge clk);
    chk("busy_after_a", busy, 1);
    in_stream = b;
    twiddle = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_stream = '0;
    twiddle = '0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 33);
    s = out_stream;
    @(negedge clk);
    chk("dif_valid", out_valid, 1);
    d = out_stream;
    @(negedge clk);
    chk("valid_drop", out_valid, 0);
    chk("dif_hold", out_stream, d);
    chk("ready_back", in_ready, 1);
    chk("busy_drop", busy, 0);
  endtask
  initial begin
    logic [31:0] s, d, a, b, w;
    longint t;
    int lo, pulses;
    logic [31:0] acc[$];
    logic [31:0] outs[$];
    logic [31:0] word;
    vecs[0] = '{32'd5, 32'd7, 32'd3, 32'd26, 32'd3313};
    vecs[1] = '{32'd3000, 32'd1000, 32'd2, 32'd1671, 32'd1000};
    vecs[2] = '{32'd0, 32'd3328, 32'd3328, 32'd1, 32'd3328};
    vecs[3] = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_pair(vecs[i].a, vecs[i].b, vecs[i].w, s, d);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].s);
      chk($sformatf("vec%0d_dif", i), d, vecs[i].d);
    end
    // Busy drop: a new word every cycle, in_valid held high.
    word = 32'd10;
    in_valid = 1'b1;
    twiddle = 32'd2;
    lo = 0;
    for (int c = 0; c < 38; c++) begin
      if (out_valid) outs.push_back(out_stream);
      in_stream = word;
      if (in_ready) acc.push_back(word);
      else lo++;
      word++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("drop_accepted", acc.size(), 4);
    chk("drop_a", acc[0], 10);
    chk("drop_b", acc[1], 11);
    chk("drop_next_a", acc[2], 46);
    chk("drop_ready_low", lo, 34);
    chk("drop_outs", outs.size(), 2);
    if (outs.size() == 2) begin
      chk("drop_sum", outs[0], 32);
      chk("drop_dif", outs[1], 3317);
    end
    do_reset();
    // Mid-multiply reset.
    in_valid = 1'b1;
    in_stream = 32'd9;
    @(negedge clk);
    twiddle = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 45; c++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    chk("mid_no_pulse", pulses, 0);
    chk("mid_out_stream", out_stream, 0);
    chk("mid_busy_low", busy, 0);
    chk("mid_in_ready", in_ready, 1);
    run_pair(32'd1, 32'd1, 32'd1, s, d);
    chk("mid_after_sum", s, 2);
    chk("mid_after_dif", d, 0);
`ifdef NTT_BFLY_RANGE_CHECK_EN
    run_pair(32'd3329, 32'd4, 32'd1, s, d);
    chk("range_sum", s, 4);
    chk("range_dif", d, 3325);
    chk("range_err_set", range_err, 1);
    run_pair(32'd5, 32'd7, 32'd3, s, d);
    chk("range_err_sticky", range_err, 1);
    do_reset();
`else
    chk("range_err_off", range_err, 0);
`endif
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 3328);
      b = $urandom_range(0, 3328);
      w = i == 0 ? 32'd3328 : $urandom_range(0, 3328);
      t = (longint'(w) * longint'(b)) % Q;
      run_pair(a, b, w, s, d);
      chk($sformatf("rnd%0d_sum", i), s, (longint'(a) + t) % Q);
      chk($sformatf("rnd%0d_dif", i), d, (longint'(a) + Q - t) % Q);
    end
    chk("final_range_err", range_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
